// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants for PC generation and branch prediction.
package cpu_pkg;

    localparam int unsigned PC_W   = 32;
    localparam int unsigned PC_INC = 4;
    localparam int unsigned CTR_W  = 2;

    typedef logic [CTR_W-1:0] ctr_t;

    localparam ctr_t CTR_MIN     = 2'b00;
    localparam ctr_t CTR_WEAK_NT = 2'b01;
    localparam ctr_t CTR_WEAK_T  = 2'b10;
    localparam ctr_t CTR_MAX     = 2'b11;

endpackage

// File: rtl/sat_counter2.sv
// Two-bit saturating direction counter: next value given the resolved direction.
module sat_counter2
    import cpu_pkg::*;
(
    input  ctr_t ctr_i,
    input  logic taken_i,
    output ctr_t ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != CTR_MAX) begin
                ctr_o = ctr_i + ctr_t'(1);
            end
        end else if (ctr_i != CTR_MIN) begin
            ctr_o = ctr_i - ctr_t'(1);
        end
    end

endmodule

// File: rtl/next_pc_predictor.sv
// Next-PC selection with a direct-mapped BTB, trained by resolved branches from EX.
module next_pc_predictor
    import cpu_pkg::*;
#(
    parameter int unsigned ENTRIES = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [PC_W-1:0] pc_cur,
    input  logic            stall,
    input  logic            ex_update,
    input  logic [PC_W-1:0] ex_pc,
    input  logic            ex_taken,
    input  logic [PC_W-1:0] ex_target,
    input  logic            ex_redirect,
    input  logic [PC_W-1:0] ex_redirect_pc,
    output logic [PC_W-1:0] next_pc,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    output logic [31:0]     branch_count,
    output logic [31:0]     mispredict_count
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = PC_W - IDX_W - 2;
    localparam int unsigned CNT_W = 32;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [TAG_W-1:0] tag_t;

    logic [ENTRIES-1:0] valid_q;
    tag_t               tag_q    [ENTRIES];
    logic [PC_W-1:0]    target_q [ENTRIES];
    ctr_t               ctr_q    [ENTRIES];

    logic [CNT_W-1:0] branch_count_q, branch_count_d;
    logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

    // Lookup side, purely from pc_cur and the pre-update table.
    idx_t            lk_idx;
    tag_t            lk_tag;
    logic            lk_hit;
    logic [PC_W-1:0] pc_plus4;

    assign lk_idx      = pc_cur[IDX_W+1:2];
    assign lk_tag      = pc_cur[PC_W-1:IDX_W+2];
    assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pc_plus4    = pc_cur + PC_W'(PC_INC);
    assign pred_taken  = lk_hit && ctr_q[lk_idx][1];
    assign pred_target = lk_hit ? target_q[lk_idx] : pc_plus4;

    // A redirect from EX beats a hazard stall, which beats the prediction.
    always_comb begin
        next_pc = pc_plus4;
        if (ex_redirect) begin
            next_pc = ex_redirect_pc;
        end else if (stall) begin
            next_pc = pc_cur;
        end else if (pred_taken) begin
            next_pc = pred_target;
        end
    end

    // Training side, indexed by the resolved branch's PC.
    idx_t up_idx;
    tag_t up_tag;
    logic up_hit;
    logic up_train;
    logic up_alloc;
    logic up_wr_target;
    ctr_t up_ctr_next;

    logic [1:0] unused_ex_pc_lsbs;
    assign unused_ex_pc_lsbs = ex_pc[1:0];

    assign up_idx       = ex_pc[IDX_W+1:2];
    assign up_tag       = ex_pc[PC_W-1:IDX_W+2];
    assign up_hit       = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign up_train     = ex_update && up_hit;
    assign up_alloc     = ex_update && !up_hit && ex_taken;
    assign up_wr_target = up_alloc || (up_train && ex_taken);

    sat_counter2 u_sat_counter2 (
        .ctr_i   (ctr_q[up_idx]),
        .taken_i (ex_taken),
        .ctr_o   (up_ctr_next)
    );

    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (ex_update) begin
            branch_count_d = branch_count_q + CNT_W'(1);
        end
        if (ex_redirect) begin
            mispredict_count_d = mispredict_count_q + CNT_W'(1);
        end
    end

    // Valid bits, direction counters and perf counters need a defined reset state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q            <= '0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                ctr_q[i] <= CTR_WEAK_NT;
            end
        end else begin
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
            if (up_alloc) begin
                valid_q[up_idx] <= 1'b1;
                ctr_q[up_idx]   <= CTR_WEAK_T;
            end else if (up_train) begin
                ctr_q[up_idx]   <= up_ctr_next;
            end
        end
    end

    // Tags and targets are only meaningful behind a valid bit, so they carry no reset.
    always_ff @(posedge clock) begin
        if (!reset && up_wr_target) begin
            target_q[up_idx] <= ex_target;
            if (up_alloc) begin
                tag_q[up_idx] <= up_tag;
            end
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_next_pc_predictor.sv
// Self-checking bench: directed vectors plus a per-cycle comparison against an abstract BTB model.
module tb_next_pc_predictor;

    localparam int NENT = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_cur = 32'h100;
    logic        stall = 1'b0;
    logic        ex_update = 1'b0;
    logic [31:0] ex_pc = 32'h0;
    logic        ex_taken = 1'b0;
    logic [31:0] ex_target = 32'h0;
    logic        ex_redirect = 1'b0;
    logic [31:0] ex_redirect_pc = 32'h0;
    logic [31:0] next_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int n_cmp = 0;
    int n_bad = 0;

    next_pc_predictor #(.ENTRIES(NENT)) dut (
        .clock            (clock),
        .reset            (reset),
        .pc_cur           (pc_cur),
        .stall            (stall),
        .ex_update        (ex_update),
        .ex_pc            (ex_pc),
        .ex_taken         (ex_taken),
        .ex_target        (ex_target),
        .ex_redirect      (ex_redirect),
        .ex_redirect_pc   (ex_redirect_pc),
        .next_pc          (next_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Abstract model: a table keyed by word-address modulo size, tag = pc / 64.
    bit          m_valid  [NENT];
    logic [31:0] m_tag    [NENT];
    logic [31:0] m_target [NENT];
    int          m_ctr    [NENT];
    logic [31:0] m_bc, m_mc;

    function automatic int slot(input logic [31:0] pc);
        return int'((pc / 4) % NENT);
    endfunction

    function automatic logic [31:0] tagof(input logic [31:0] pc);
        return pc / 64;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NENT; i++) begin
                m_valid[i] <= 1'b0;
                m_ctr[i]   <= 1;
            end
            m_bc <= 0;
            m_mc <= 0;
        end else begin
            if (ex_redirect) m_mc <= m_mc + 1;
            if (ex_update) begin
                int s;
                s = slot(ex_pc);
                m_bc <= m_bc + 1;
                if (m_valid[s] && m_tag[s] == tagof(ex_pc)) begin
                    if (ex_taken) begin
                        m_ctr[s]    <= (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
                        m_target[s] <= ex_target;
                    end else begin
                        m_ctr[s] <= (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
                    end
                end else if (ex_taken) begin
                    m_valid[s]  <= 1'b1;
                    m_tag[s]    <= tagof(ex_pc);
                    m_target[s] <= ex_target;
                    m_ctr[s]    <= 2;
                end
            end
        end
    end

    always @(negedge clock) begin
        int          s;
        bit          hit, ptk;
        logic [31:0] ptg, npc;
        s   = slot(pc_cur);
        hit = m_valid[s] && (m_tag[s] == tagof(pc_cur));
        ptk = hit && (m_ctr[s] >= 2);
        ptg = hit ? m_target[s] : pc_cur + 32'd4;
        if (ex_redirect)  npc = ex_redirect_pc;
        else if (stall)   npc = pc_cur;
        else if (ptk)     npc = ptg;
        else              npc = pc_cur + 32'd4;
        chk("model_pred_taken", {31'b0, pred_taken}, {31'b0, ptk});
        chk("model_pred_target", pred_target, ptg);
        chk("model_next_pc", next_pc, npc);
        chk("model_branch_count", branch_count, m_bc);
        chk("model_mispredict_count", mispredict_count, m_mc);
    end

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        ex_update = 1'b1;
        ex_pc     = pc;
        ex_taken  = tk;
        ex_target = tgt;
        cyc();
        ex_update = 1'b0;
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        chk("reset_next_pc", next_pc, 32'h104);
        chk("reset_pred_taken", {31'b0, pred_taken}, 32'h0);
        chk("reset_branch_count", branch_count, 32'h0);
        chk("reset_mispredict_count", mispredict_count, 32'h0);

        upd(32'h100, 1'b1, 32'h200);
        chk("alloc_pred_taken", {31'b0, pred_taken}, 32'h1);
        chk("alloc_next_pc", next_pc, 32'h200);
        chk("alloc_branch_count", branch_count, 32'h1);

        upd(32'h100, 1'b0, 32'h0);
        chk("nt1_pred_taken", {31'b0, pred_taken}, 32'h0);
        chk("nt1_next_pc", next_pc, 32'h104);
        chk("nt1_pred_target", pred_target, 32'h200);
        upd(32'h100, 1'b0, 32'h0);
        upd(32'h100, 1'b0, 32'h0);
        chk("nt3_sat_low", {31'b0, pred_taken}, 32'h0);
        upd(32'h100, 1'b1, 32'h200);
        chk("sat0_plus1_not_taken", {31'b0, pred_taken}, 32'h0);
        upd(32'h100, 1'b1, 32'h200);
        chk("ctr2_taken", {31'b0, pred_taken}, 32'h1);
        upd(32'h100, 1'b1, 32'h280);
        chk("retarget_next_pc", next_pc, 32'h280);
        upd(32'h100, 1'b1, 32'h280);
        upd(32'h100, 1'b0, 32'h0);
        chk("sat3_minus1_taken", {31'b0, pred_taken}, 32'h1);
        upd(32'h100, 1'b0, 32'h0);
        chk("ctr1_not_taken", {31'b0, pred_taken}, 32'h0);
        chk("train_branch_count", branch_count, 32'd10);
        upd(32'h100, 1'b1, 32'h280);

        ex_redirect    = 1'b1;
        ex_redirect_pc = 32'h300;
        stall          = 1'b1;
        #1;
        chk("redirect_over_stall", next_pc, 32'h300);
        cyc();
        ex_redirect = 1'b0;
        #1;
        chk("redirect_count", mispredict_count, 32'h1);
        chk("stall_holds_pc", next_pc, 32'h100);
        stall = 1'b0;

        upd(32'h140, 1'b1, 32'h500);
        chk("alias_old_miss", next_pc, 32'h104);
        pc_cur = 32'h140;
        #1;
        chk("alias_new_hit", next_pc, 32'h500);

        pc_cur = 32'hFFFF_FFFC;
        #1;
        chk("wrap_next_pc", next_pc, 32'h0);

        ex_redirect    = 1'b1;
        ex_redirect_pc = 32'h40;
        cyc();
        ex_redirect = 1'b0;
        #1;
        chk("jr_mispredict_count", mispredict_count, 32'h2);
        chk("jr_branch_count", branch_count, 32'd12);

        pc_cur    = 32'h108;
        ex_update = 1'b1;
        ex_pc     = 32'h108;
        ex_taken  = 1'b1;
        ex_target = 32'h600;
        #1;
        chk("no_bypass_next_pc", next_pc, 32'h10C);
        cyc();
        ex_update = 1'b0;
        #1;
        chk("post_update_next_pc", next_pc, 32'h600);

        pc_cur = 32'h140;
        #1;
        chk("pre_reset_hit", next_pc, 32'h500);
        reset     = 1'b1;
        ex_update = 1'b1;
        ex_pc     = 32'h180;
        ex_taken  = 1'b1;
        ex_target = 32'h700;
        #1;
        chk("async_reset_pred", {31'b0, pred_taken}, 32'h0);
        chk("async_reset_next_pc", next_pc, 32'h144);
        chk("async_reset_bc", branch_count, 32'h0);
        chk("async_reset_mc", mispredict_count, 32'h0);
        cyc();
        reset     = 1'b0;
        ex_update = 1'b0;
        pc_cur    = 32'h180;
        #1;
        chk("no_update_in_reset", next_pc, 32'h184);
        chk("no_count_in_reset", branch_count, 32'h0);

        repeat (2) cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
